alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing a single registered ALU.
// Each operation is issued in IDLE, evaluated in EXEC and held in RESP until the consumer accepts it.

module alu_arbiter_alu #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_uc,
    output logic [WIDTH-1:0] o_result,
    output logic             o_n,
    output logic             o_z,
    output logic             o_c,
    output logic             o_v,
    output logic             o_err
);
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;

    always_comb begin
        o_result = '0;
        o_c      = 1'b0;
        o_v      = 1'b0;
        o_err    = 1'b0;
        w_sum    = '0;
        w_prod   = '0;
        case (i_uc)
            4'd0: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[WIDTH-1:0];
                o_c      = w_sum[WIDTH];
                o_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            4'd1: begin
                o_result = i_a - i_b;
                o_c      = i_a < i_b;
                o_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (o_result[WIDTH-1] != i_a[WIDTH-1]);
            end
            4'd2: begin
                w_prod   = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
                o_result = w_prod[WIDTH-1:0];
                o_c      = |w_prod[2*WIDTH-1:WIDTH];
            end
            4'd3: begin
                if (i_b == '0) o_err = 1'b1;
                else           o_result = i_a / i_b;
            end
            4'd4: begin
                if (i_b == '0) o_err = 1'b1;
                else           o_result = i_a % i_b;
            end
            4'd5: o_result = i_a & i_b;
            4'd6: o_result = i_a | i_b;
            4'd7: o_result = i_a ^ i_b;
            4'd8: begin
                o_result = i_a << i_b;
                // carry flags any set bit of a pushed out of the top by the shift
                o_c      = |(i_a & ~({WIDTH{1'b1}} >> i_b));
            end
            default: o_err = 1'b1;
        endcase
        o_n = o_result[WIDTH-1];
        o_z = (o_result == '0);
    end
endmodule

module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    input  logic             r1_valid,
    output logic             r0_ready,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [3:0]       r0_uc,
    input  logic [3:0]       r1_uc,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_n,
    output logic             rsp_z,
    output logic             rsp_c,
    output logic             rsp_v,
    output logic             rsp_err,
    output logic             busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           r_state;
    logic             r_prio;
    logic [WIDTH-1:0] r_a, r_b;
    logic [3:0]       r_uc;
    logic             r_id;
    logic             r_rsp_valid, r_rsp_id, r_n, r_z, r_c, r_v, r_err, r_busy;
    logic [WIDTH-1:0] r_result;

    logic             w_grant_id, w_take;
    logic [WIDTH-1:0] w_result;
    logic             w_n, w_z, w_c, w_v, w_err;

    // r_prio names the requester that wins when both are valid
    always_comb begin
        w_grant_id = (r0_valid && r1_valid) ? r_prio : r1_valid;
        w_take     = rst_n && (r_state == S_IDLE) && (r0_valid || r1_valid);
    end

    assign r0_ready = w_take && !w_grant_id;
    assign r1_ready = w_take &&  w_grant_id;

    alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_uc     (r_uc),
        .o_result (w_result),
        .o_n      (w_n),
        .o_z      (w_z),
        .o_c      (w_c),
        .o_v      (w_v),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_prio      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_uc        <= '0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_result    <= '0;
            r_n         <= 1'b0;
            r_z         <= 1'b0;
            r_c         <= 1'b0;
            r_v         <= 1'b0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_a     <= w_grant_id ? r1_a  : r0_a;
                        r_b     <= w_grant_id ? r1_b  : r0_b;
                        r_uc    <= w_grant_id ? r1_uc : r0_uc;
                        r_id    <= w_grant_id;
                        r_prio  <= ~w_grant_id;
                        r_busy  <= 1'b1;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_result    <= w_result;
                    r_n         <= w_n;
                    r_z         <= w_z;
                    r_c         <= w_c;
                    r_v         <= w_v;
                    r_err       <= w_err;
                    r_rsp_id    <= r_id;
                    r_rsp_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_result;
    assign rsp_n      = r_n;
    assign rsp_z      = r_z;
    assign rsp_c      = r_c;
    assign rsp_v      = r_v;
    assign rsp_err    = r_err;
    assign busy       = r_busy;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with an arithmetic reference model.
module tb_alu_arbiter;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         r0_valid, r1_valid, r0_ready, r1_ready;
    logic [W-1:0] r0_a, r0_b, r1_a, r1_b;
    logic [3:0]   r0_uc, r1_uc;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_n, rsp_z, rsp_c, rsp_v, rsp_err, busy;

    int checks = 0;
    int errors = 0;
    int last   = 1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r1_a(r1_a), .r1_b(r1_b),
        .r0_uc(r0_uc), .r1_uc(r1_uc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_n(rsp_n), .rsp_z(rsp_z),
        .rsp_c(rsp_c), .rsp_v(rsp_v), .rsp_err(rsp_err), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sgn(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    function automatic void ref_alu(input int a, input int b, input int uc,
                                    output int res, output int n, output int z,
                                    output int c, output int v, output int err);
        int full;
        int s;
        res = 0; c = 0; v = 0; err = 0;
        case (uc)
            0: begin full = a + b; res = full % M; c = (full >= M) ? 1 : 0;
                     s = sgn(a) + sgn(b); v = (s >= M / 2 || s < -M / 2) ? 1 : 0; end
            1: begin res = (a - b + M) % M; c = (a < b) ? 1 : 0;
                     s = sgn(a) - sgn(b); v = (s >= M / 2 || s < -M / 2) ? 1 : 0; end
            2: begin full = a * b; res = full % M; c = (full >= M) ? 1 : 0; end
            3: if (b == 0) err = 1; else res = a / b;
            4: if (b == 0) err = 1; else res = a % b;
            5: res = a & b;
            6: res = a | b;
            7: res = a ^ b;
            8: begin full = a * (1 << b); res = full % M; c = (full >= M) ? 1 : 0; end
            default: err = 1;
        endcase
        n = (res >= M / 2) ? 1 : 0;
        z = (res == 0) ? 1 : 0;
    endfunction

    // Called #1 after a rising edge with the DUT in IDLE.
    task automatic txn(input bit v0, input bit v1,
                       input int a0, input int b0, input int u0,
                       input int a1, input int b1, input int u1, input int hold);
        int g, a, b, u, res, n, z, c, v, err;
        g = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
        r0_valid = v0; r1_valid = v1;
        r0_a = W'(a0); r0_b = W'(b0); r0_uc = 4'(u0);
        r1_a = W'(a1); r1_b = W'(b1); r1_uc = 4'(u1);
        #1;
        chk("idle_r0_ready", 32'(r0_ready), (g == 0) ? 1 : 0);
        chk("idle_r1_ready", 32'(r1_ready), (g == 1) ? 1 : 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_rsp_valid", 32'(rsp_valid), 0);
        last = g;
        a = (g == 1) ? a1 : a0;
        b = (g == 1) ? b1 : b0;
        u = (g == 1) ? u1 : u0;
        ref_alu(a, b, u, res, n, z, c, v, err);
        @(posedge clk); #1;
        chk("exec_busy", 32'(busy), 1);
        chk("exec_rsp_valid", 32'(rsp_valid), 0);
        chk("exec_ready", 32'({r0_ready, r1_ready}), 0);
        @(posedge clk); #1;
        for (int k = 0; k <= hold; k++) begin
            chk("resp_valid", 32'(rsp_valid), 1);
            chk("resp_id", 32'(rsp_id), g);
            chk("resp_result", 32'(rsp_result), res);
            chk("resp_flags", 32'({rsp_n, rsp_z, rsp_c, rsp_v}), (n << 3) | (z << 2) | (c << 1) | v);
            chk("resp_err", 32'(rsp_err), err);
            chk("resp_ready", 32'({r0_ready, r1_ready}), 0);
            chk("resp_busy", 32'(busy), 1);
            if (k < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("done_rsp_valid", 32'(rsp_valid), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_result_hold", 32'(rsp_result), res);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0; r0_uc = '0; r1_uc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'({r0_ready, r1_ready}), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'({rsp_id, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err}), 0);
        rst_n = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;

        // Continuous contention alternates r0, r1, r0, r1
        txn(1, 1, 1, 2, 0, 3, 4, 5, 0);
        txn(1, 1, 5, 3, 1, 6, 3, 2, 0);
        txn(1, 1, 2, 2, 7, 12, 5, 3, 0);
        txn(1, 1, 9, 1, 8, 8, 8, 6, 0);

        txn(1, 0, 7, 9, 0, 0, 0, 0, 0);     // 7+9: result 0, z, c
        txn(0, 1, 0, 0, 0, 9, 0, 3, 0);     // divide by zero
        txn(1, 0, 3, 4, 9, 0, 0, 0, 0);     // illegal opcode 1001
        txn(0, 1, 0, 0, 0, 10, 0, 4, 0);    // mod by zero
        txn(1, 0, 7, 1, 0, 0, 0, 0, 0);     // signed overflow
        txn(1, 1, 2, 5, 1, 13, 3, 2, 5);    // response stalled 5 cycles

        // Reset during EXEC discards the operation and restores r0 priority
        r0_valid = 1'b0; r1_valid = 1'b1; r1_a = 4'd5; r1_b = 4'd2; r1_uc = 4'd0;
        @(posedge clk); #1;
        r0_valid = 1'b1;
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_ready", 32'({r0_ready, r1_ready}), 0);
        last = 1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", 32'({rsp_valid, busy}), 0);
        end
        txn(1, 1, 4, 4, 0, 1, 1, 0, 0);

        for (int i = 0; i < 40; i++) begin
            bit v0, v1;
            int bb0, bb1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            bb0 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, M - 1));
            bb1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, M - 1));
            txn(v0, v1,
                int'($urandom_range(0, M - 1)), bb0, int'($urandom_range(0, 10)),
                int'($urandom_range(0, M - 1)), bb1, int'($urandom_range(0, 10)),
                int'($urandom_range(0, 2)));
        end
        r0_valid = 1'b0; r1_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
